mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: a read-only fetch port and a load/store port share a
// single downstream memory interface. Grants alternate on ties, misaligned
// accesses are rejected without touching memory, and a stalled downstream
// access is aborted after TIMEOUT busy cycles.
module mem_arbiter #(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            reset,
  // fetch port
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_ready,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_error,
  // load/store port
  input  logic            lsu_req,
  input  logic            lsu_we,
  input  logic [XLEN-1:0] lsu_addr,
  input  logic [XLEN-1:0] lsu_wdata,
  output logic            lsu_ready,
  output logic [XLEN-1:0] lsu_rdata,
  output logic            lsu_error,
  // downstream memory
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            mem_error,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state;
  state_t      state_next;
  logic        port;        // port of the transaction in flight: 0 fetch, 1 LSU
  logic        last_grant;  // port granted most recently: 0 fetch, 1 LSU
  logic [7:0]  count;       // BUSY cycles elapsed without mem_ready

  logic            grant;
  logic            grant_lsu;
  logic [XLEN-1:0] sel_addr;
  logic            misaligned;
  logic            expire;

  // Arbitration: a lone requester wins outright; on a tie the port that was
  // not served last wins.
  assign grant      = (state == IDLE) && (if_req || lsu_req);
  assign grant_lsu  = lsu_req && (!if_req || !last_grant);
  assign sel_addr   = grant_lsu ? lsu_addr : if_addr;
  assign misaligned = (sel_addr[1:0] != 2'b00);
  assign expire     = (count == 8'(TIMEOUT - 1));

  assign mem_req   = (state == BUSY);
  assign busy      = (state != IDLE);
  assign if_ready  = (state == RESP) && !port;
  assign lsu_ready = (state == RESP) && port;

  // Next-state logic; mem_ready takes priority over the timeout expiry.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_next = misaligned ? RESP : BUSY;
        end
      end
      BUSY: begin
        if (mem_ready || expire) begin
          state_next = RESP;
        end
      end
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register, request latches, timeout counter and per-port response
  // registers (which hold their value between ready pulses).
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      port       <= 1'b0;
      last_grant <= 1'b0;
      count      <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      if_rdata   <= '0;
      if_error   <= 1'b0;
      lsu_rdata  <= '0;
      lsu_error  <= 1'b0;
    end else begin
      state <= state_next;
      if (grant) begin
        port       <= grant_lsu;
        last_grant <= grant_lsu;
        count      <= 8'd0;
        mem_we     <= grant_lsu & lsu_we;
        mem_addr   <= sel_addr;
        mem_wdata  <= grant_lsu ? lsu_wdata : '0;
        // Misaligned accesses are answered immediately with an error.
        if (misaligned) begin
          if (grant_lsu) begin
            lsu_rdata <= '0;
            lsu_error <= 1'b1;
          end else begin
            if_rdata <= '0;
            if_error <= 1'b1;
          end
        end
      end else if (state == BUSY) begin
        if (mem_ready) begin
          if (port) begin
            lsu_rdata <= mem_rdata;
            lsu_error <= mem_error;
          end else begin
            if_rdata <= mem_rdata;
            if_error <= mem_error;
          end
        end else if (expire) begin
          if (port) begin
            lsu_rdata <= '0;
            lsu_error <= 1'b1;
          end else begin
            if_rdata <= '0;
            if_error <= 1'b1;
          end
        end else begin
          count <= count + 8'd1;
        end
      end
    end
  end

endmodule
